// File: rtl/output_pref_if.sv
// Handshake bundle between the systolic array, output_pref and the ping-pong output buffers.
// master = SA / buffer side, slave = output_pref.
interface output_pref_if #(
  parameter int N    = 8,
  parameter int PW   = 16,
  parameter int ROWS = 4,
  parameter int AW   = 3
);
  logic                sa_valid;
  logic                sa_ready;
  logic [ROWS*PW-1:0]  sa_psum;
  logic                sa_last;
  logic                ob0_wr_en;
  logic                ob1_wr_en;
  logic                ob_wr_ready;
  logic [AW-1:0]       ob_wr_addr;
  logic [ROWS*N-1:0]   ob_wr_data;

  modport master (
    output sa_valid, sa_psum, sa_last, ob_wr_ready,
    input  sa_ready, ob0_wr_en, ob1_wr_en, ob_wr_addr, ob_wr_data
  );

  modport slave (
    input  sa_valid, sa_psum, sa_last, ob_wr_ready,
    output sa_ready, ob0_wr_en, ob1_wr_en, ob_wr_addr, ob_wr_data
  );
endinterface

// File: rtl/output_pref.sv
// Output write-back: quantizes SA partial-sum beats, buffers them and writes one word per column
// into the selected ping-pong buffer. Define OUTPUT_PREF_RELU_EN to clamp negative lanes to zero.
//
// state   | meaning
// IDLE    | waiting for the first beat of a tile; latches buf_select on it
// COLLECT | accepting beats until sa_last or the COLS-th beat
// FLUSH   | no new beats; draining quantize stage and FIFO to the buffer
// DONE    | tile_done pulse, back to IDLE
module output_pref #(
  parameter int N     = 8,
  parameter int PW    = 16,
  parameter int ROWS  = 4,
  parameter int COLS  = 8,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         buf_select,
  output_pref_if.slave bus,
  output logic         busy,
  output logic         tile_done
);
  localparam int PTRW = $clog2(DEPTH);
  localparam logic [PTRW:0]      READY_MAX = (PTRW+1)'(DEPTH - 2);
  localparam logic [AW:0]        LAST_BEAT = (AW+1)'(COLS - 1);
  localparam logic [AW-1:0]      ADDR_MAX  = AW'(COLS - 1);
  localparam logic signed [PW:0] ROUND     = (PW+1)'(1 << (SHIFT - 1));
  localparam logic signed [PW:0] QMAX      = (PW+1)'((1 << (N - 1)) - 1);
  localparam logic signed [PW:0] QMIN      = (PW+1)'(-(1 << (N - 1)));

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

  function automatic logic [N-1:0] quant(input logic [PW-1:0] psum);
    logic signed [PW:0] t;
    logic signed [PW:0] q;
    t = $signed({psum[PW-1], psum}) + ROUND;
    q = t >>> SHIFT;
`ifdef OUTPUT_PREF_RELU_EN
    if (t[PW]) q = '0;
`endif
    if (q > QMAX) q = QMAX;
    else if (q < QMIN) q = QMIN;
    return q[N-1:0];
  endfunction

  state_t             state;
  logic               sel_q;
  logic [AW:0]        beat_cnt;
  logic [AW-1:0]      addr_q;

  logic               q_valid;
  logic [ROWS*N-1:0]  q_data;
  logic [ROWS*N-1:0]  q_next;
  logic [ROWS*N-1:0]  mem [DEPTH];
  logic [PTRW-1:0]    wr_ptr;
  logic [PTRW-1:0]    rd_ptr;
  logic [PTRW:0]      count;

  logic               accept;
  logic               push;
  logic               pop;
  logic               fifo_nonempty;
  logic               accepting_state;

  always_comb begin
    q_next = '0;
    for (int r = 0; r < ROWS; r++) q_next[r*N +: N] = quant(bus.sa_psum[r*PW +: PW]);
  end

  // One FIFO slot stays free for the beat sitting in the quantize stage.
  assign fifo_nonempty   = (count != '0);
  assign accepting_state = (state == IDLE) || (state == COLLECT);
  assign bus.sa_ready    = en && !reset_n && accepting_state && (count <= READY_MAX);
  assign accept          = bus.sa_valid && bus.sa_ready;
  assign push            = q_valid;
  assign pop             = fifo_nonempty && bus.ob_wr_ready;

  assign bus.ob0_wr_en  = fifo_nonempty && !sel_q;
  assign bus.ob1_wr_en  = fifo_nonempty && sel_q;
  assign bus.ob_wr_addr = addr_q;
  assign bus.ob_wr_data = fifo_nonempty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      q_valid <= accept;
      if (accept) q_data <= q_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q_data;
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state     <= IDLE;
      sel_q     <= 1'b0;
      beat_cnt  <= '0;
      addr_q    <= '0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      if (pop) addr_q <= (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            sel_q    <= buf_select;
            addr_q   <= '0;
            beat_cnt <= (AW+1)'(1);
            busy     <= 1'b1;
            state    <= (bus.sa_last || LAST_BEAT == '0) ? FLUSH : COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (bus.sa_last || beat_cnt == LAST_BEAT) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!q_valid && !fifo_nonempty) begin
            state     <= DONE;
            tile_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_pref.sv
// Randomized self-checking bench for output_pref; expected writes come from an integer-arithmetic
// model of the quantizer and the tile rules, kept as a queue of {buffer, address, word}.
`timescale 1ns/1ps
module tb_output_pref;
  localparam int N = 8, PW = 16, ROWS = 4, COLS = 8, SHIFT = 4, DEPTH = 4, AW = 3;
  localparam int EW = 1 + AW + ROWS*N;
`ifdef OUTPUT_PREF_RELU_EN
  localparam logic [31:0] EXP1 = 32'h007F0012;
`else
  localparam logic [31:0] EXP1 = 32'h807FFE12;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  logic buf_select;
  logic busy;
  logic tile_done;

  output_pref_if #(.N(N), .PW(PW), .ROWS(ROWS), .AW(AW)) bus ();

  output_pref #(
    .N(N), .PW(PW), .ROWS(ROWS), .COLS(COLS), .SHIFT(SHIFT), .DEPTH(DEPTH), .AW(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .buf_select(buf_select),
    .bus(bus), .busy(busy), .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] quant_ref(input logic [PW-1:0] raw);
    int v, t, q;
    v = int'($signed(raw));
    t = v + (1 << (SHIFT - 1));
    q = t >>> SHIFT;
`ifdef OUTPUT_PREF_RELU_EN
    if (t < 0) q = 0;
`endif
    if (q > (1 << (N - 1)) - 1) q = (1 << (N - 1)) - 1;
    if (q < -(1 << (N - 1))) q = -(1 << (N - 1));
    return q[N-1:0];
  endfunction

  function automatic logic [ROWS*N-1:0] expect_word(input logic [ROWS*PW-1:0] psum);
    logic [ROWS*N-1:0] w;
    w = '0;
    for (int r = 0; r < ROWS; r++) w[r*N +: N] = quant_ref(psum[r*PW +: PW]);
    return w;
  endfunction

  function automatic logic [ROWS*PW-1:0] rand_psum();
    logic [ROWS*PW-1:0] p;
    p = '0;
    for (int r = 0; r < ROWS; r++) begin
      case ($urandom_range(0, 3))
        0:       p[r*PW +: PW] = PW'(2000 + int'($urandom_range(0, 80)));
        1:       p[r*PW +: PW] = PW'(-2090 + int'($urandom_range(0, 80)));
        2:       p[r*PW +: PW] = PW'(int'($urandom_range(0, 64)) - 32);
        default: p[r*PW +: PW] = PW'($urandom);
      endcase
    end
    return p;
  endfunction

  // reference model state
  logic [EW-1:0] exp_q[$];
  bit tile_open = 1'b0;
  bit tile_sel = 1'b0;
  int tile_beats = 0;
  int tiles_ended = 0, tiles_done = 0, done_pulses = 0;
  int wr_cnt = 0, wr0_cnt = 0, wr1_cnt = 0;

  bit rand_ready = 1'b0, rand_en = 1'b0;
  bit ready_fix = 1'b1, en_fix = 1'b1;

  initial begin
    bus.ob_wr_ready = 1'b0;
    en = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.ob_wr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fix;
      en = rand_en ? ($urandom_range(0, 4) != 0) : en_fix;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      logic [EW-1:0] e;
      bit flushing;
      flushing = (tiles_ended > tiles_done);
      chk("busy", busy, tile_open || flushing);
      chk("wr_exclusive", bus.ob0_wr_en && bus.ob1_wr_en, 0);
      if (flushing) chk("ready_in_flush", bus.sa_ready, 0);
      if ((bus.ob0_wr_en || bus.ob1_wr_en) && bus.ob_wr_ready) begin
        wr_cnt++;
        if (bus.ob0_wr_en) wr0_cnt++;
        if (bus.ob1_wr_en) wr1_cnt++;
        if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("wr_word", {bus.ob1_wr_en, bus.ob_wr_addr, bus.ob_wr_data}, e);
        end
      end
      if (tile_done) begin
        chk("done_after_tile_end", flushing, 1);
        chk("done_drained", exp_q.size(), 0);
        if (flushing) tiles_done++;
        done_pulses++;
      end
      if (bus.sa_valid && bus.sa_ready) begin
        if (!tile_open) begin
          tile_open  = 1'b1;
          tile_sel   = buf_select;
          tile_beats = 0;
        end
        e = {tile_sel, tile_beats[AW-1:0], expect_word(bus.sa_psum)};
        exp_q.push_back(e);
        tile_beats++;
        if (bus.sa_last || tile_beats == COLS) begin
          tile_open = 1'b0;
          tiles_ended++;
        end
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the transfer edge
  task automatic drive_beat(input logic [ROWS*PW-1:0] d, input logic last, output int cycles);
    bit ok;
    ok = 1'b0;
    cycles = 0;
    bus.sa_valid = 1'b1;
    bus.sa_psum  = d;
    bus.sa_last  = last;
    while (!ok && cycles < 200) begin
      @(negedge clk);
      ok = bus.sa_ready;
      @(posedge clk); #1;
      cycles++;
    end
    bus.sa_valid = 1'b0;
    bus.sa_last  = 1'b0;
    if (!ok) chk("beat_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tile_open || tiles_ended != tiles_done || exp_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, total, idx, lat, w0, w1, d0;
    logic [ROWS*PW-1:0] p;
    logic [ROWS*PW-1:0] beats [COLS];

    reset_n = 1'b1;
    buf_select = 1'b0;
    bus.sa_valid = 1'b0;
    bus.sa_psum = '0;
    bus.sa_last = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_outputs", {bus.sa_ready, bus.ob0_wr_en, bus.ob1_wr_en, bus.ob_wr_addr,
                        bus.ob_wr_data, busy, tile_done}, 0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;

    // single beat, boundary lanes, 2-cycle latency
    d0 = done_pulses;
    buf_select = 1'b0;
    drive_beat({16'h8000, 16'h7FFF, 16'hFFD8, 16'h0123}, 1'b1, cyc);
    lat = 0;
    while (!(bus.ob0_wr_en || bus.ob1_wr_en) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t1_latency", lat, 2);
    chk("t1_word", {bus.ob1_wr_en, bus.ob0_wr_en, bus.ob_wr_addr, bus.ob_wr_data},
        {2'b01, 3'd0, EXP1});
    @(posedge clk); #1;
    wait_idle();
    chk("t1_done_pulses", done_pulses - d0, 1);

    // full back-to-back tile into buffer 1
    buf_select = 1'b1;
    w1 = wr1_cnt;
    total = 0;
    for (int c = 0; c < COLS; c++) begin
      p = rand_psum();
      p[PW-1:0] = PW'(16 * c);
      drive_beat(p, c == COLS - 1, cyc);
      total += cyc;
    end
    chk("t2_no_backpressure", total, COLS);
    wait_idle();
    chk("t2_ob1_writes", wr1_cnt - w1, COLS);

    // buffer stalled while SA streams
    buf_select = 1'b0;
    for (int c = 0; c < COLS; c++) beats[c] = rand_psum();
    w0 = wr_cnt;
    ready_fix = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < COLS) begin
        bus.sa_valid = 1'b1;
        bus.sa_psum  = beats[idx];
        bus.sa_last  = (idx == COLS - 1);
      end else bus.sa_valid = 1'b0;
      @(negedge clk);
      if (bus.sa_valid && bus.sa_ready) idx++;
      @(posedge clk); #1;
    end
    bus.sa_valid = 1'b0;
    bus.sa_last = 1'b0;
    chk("t3_accepted_while_stalled", idx, DEPTH);
    chk("t3_no_writes_while_stalled", wr_cnt - w0, 0);
    ready_fix = 1'b1;
    while (idx < COLS) begin
      drive_beat(beats[idx], idx == COLS - 1, cyc);
      idx++;
    end
    wait_idle();
    chk("t3_total_writes", wr_cnt - w0, COLS);

    // buf_select toggled mid-tile
    buf_select = 1'b1;
    w0 = wr0_cnt;
    w1 = wr1_cnt;
    for (int c = 0; c < COLS; c++) begin
      if (c == 3) buf_select = 1'b0;
      drive_beat(rand_psum(), 1'b0, cyc);
    end
    wait_idle();
    chk("t4_latched_ob1", wr1_cnt - w1, COLS);
    chk("t4_latched_ob0", wr0_cnt - w0, 0);
    drive_beat(rand_psum(), 1'b0, cyc);
    drive_beat(rand_psum(), 1'b1, cyc);
    wait_idle();
    chk("t4_next_tile_ob0", wr0_cnt - w0, 2);

    // early sa_last on beat 3
    w0 = wr_cnt;
    d0 = done_pulses;
    for (int c = 0; c < 3; c++) drive_beat(rand_psum(), c == 2, cyc);
    wait_idle();
    chk("t5_writes", wr_cnt - w0, 3);
    chk("t5_done", done_pulses - d0, 1);
    drive_beat(rand_psum(), 1'b1, cyc);
    wait_idle();

    // reset with two words in the FIFO
    ready_fix = 1'b0;
    buf_select = 1'b0;
    drive_beat(rand_psum(), 1'b0, cyc);
    drive_beat(rand_psum(), 1'b0, cyc);
    @(posedge clk); #3;
    reset_n = 1'b1;
    exp_q.delete();
    tile_open = 1'b0;
    #1;
    chk("rst_mid_outputs", {bus.sa_ready, bus.ob0_wr_en, bus.ob1_wr_en, bus.ob_wr_addr,
                            bus.ob_wr_data, tile_done}, 0);
    chk("rst_mid_busy", busy, 0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    ready_fix = 1'b1;
    w0 = wr_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_stale", wr_cnt - w0, 0);

    // randomized tiles with random backpressure, enable and buffer selection
    rand_ready = 1'b1;
    rand_en = 1'b1;
    for (int t = 0; t < 12; t++) begin
      int len;
      logic last;
      buf_select = 1'($urandom_range(0, 1));
      len = $urandom_range(1, COLS);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        if ($urandom_range(0, 5) == 0) buf_select = ~buf_select;
        last = (b == len - 1) ? ((len < COLS) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
        drive_beat(rand_psum(), last, cyc);
      end
    end
    wait_idle();
    rand_ready = 1'b0;
    rand_en = 1'b0;
    wait_idle();
    chk("done_count", done_pulses, tiles_ended);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
